// File: rtl/wb_decode_n.sv
// rtl/wb_decode_n.sv - pipelined Wishbone 1:N address decoder
// Locks onto one slave while requests are outstanding; terminates disabled ports and flushes hung slaves.
module wb_decode_n #(
   parameter int                 NPORTS  = 16,
   parameter int                 PSEL_W  = 4,
   parameter int                 PSEL_HI = 31,
   parameter int                 DWIDTH  = 32,
   parameter int                 MAXPEND = 4,
   parameter int                 TIMEOUT = 255,
   parameter logic [NPORTS-1:0]  PORTEN  = '1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       m_cyc,
   input  logic                       m_stb,
   input  logic                       m_we,
   input  logic [31:0]                m_adr,
   input  logic [DWIDTH/8-1:0]        m_sel,
   input  logic [DWIDTH-1:0]          m_dat_m,
   output logic [DWIDTH-1:0]          m_dat_s,
   output logic                       m_ack,
   output logic                       m_err,
   output logic                       m_stall,
   output logic [NPORTS-1:0]          s_cyc,
   output logic [NPORTS-1:0]          s_stb,
   output logic                       s_we,
   output logic [31:0]                s_adr,
   output logic [DWIDTH/8-1:0]        s_sel,
   output logic [DWIDTH-1:0]          s_dat_m,
   input  logic [NPORTS*DWIDTH-1:0]   s_dat_s,
   input  logic [NPORTS-1:0]          s_ack,
   input  logic [NPORTS-1:0]          s_err,
   input  logic [NPORTS-1:0]          s_stall,
   output logic                       timeout_evt,
   output logic [PSEL_W-1:0]          err_port
);

   localparam int PW = $clog2(MAXPEND + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAXPEND);
   localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACTIVE, TERM, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     pend, pend_nxt;
   logic [WW-1:0]     wdog, wdog_nxt;
   logic [PSEL_W-1:0] lock, lock_nxt, err_port_nxt;
   logic [PSEL_W-1:0] dport;
   logic              accept, resp;

   assign dport   = m_adr[PSEL_HI -: PSEL_W];
   assign s_we    = m_we;
   assign s_adr   = m_adr;
   assign s_sel   = m_sel;
   assign s_dat_m = m_dat_m;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         pend     <= '0;
         wdog     <= '0;
         lock     <= '0;
         err_port <= '0;
      end else begin
         state    <= state_nxt;
         pend     <= pend_nxt;
         wdog     <= wdog_nxt;
         lock     <= lock_nxt;
         err_port <= err_port_nxt;
      end
   end

   // Everything combinational is gated by rst_i so the outputs sit at reset values during reset.
   always_comb begin
      state_nxt    = state;
      pend_nxt     = pend;
      wdog_nxt     = wdog;
      lock_nxt     = lock;
      err_port_nxt = err_port;
      s_cyc        = '0;
      s_stb        = '0;
      m_ack        = 1'b0;
      m_err        = 1'b0;
      m_stall      = 1'b0;
      m_dat_s      = '0;
      timeout_evt  = 1'b0;
      accept       = 1'b0;
      resp         = 1'b0;
      if (!m_cyc || rst_i) begin
         pend_nxt  = '0;
         wdog_nxt  = '0;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (m_stb) begin
                  if (PORTEN[dport]) begin
                     s_cyc[dport] = 1'b1;
                     s_stb[dport] = 1'b1;
                     m_stall      = s_stall[dport];
                     if (!s_stall[dport]) begin
                        lock_nxt  = dport;
                        pend_nxt  = PW'(1);
                        wdog_nxt  = '0;
                        state_nxt = ACTIVE;
                     end
                  end else begin
                     err_port_nxt = dport;
                     state_nxt    = TERM;
                  end
               end
            end
            ACTIVE: begin
               s_cyc[lock] = 1'b1;
               m_dat_s     = s_dat_s[int'(lock)*DWIDTH +: DWIDTH];
               m_err       = s_err[lock];
               m_ack       = s_ack[lock] & ~s_err[lock];
               resp        = s_ack[lock] | s_err[lock];
               if (wdog == WDOG_MAX) begin
                  timeout_evt  = 1'b1;
                  m_stall      = 1'b1;
                  err_port_nxt = lock;
               end else if (dport != lock || pend == PEND_MAX) begin
                  m_stall = 1'b1;
               end else begin
                  s_stb[lock] = m_stb;
                  m_stall     = s_stall[lock];
                  accept      = m_stb & ~s_stall[lock];
               end
               pend_nxt = pend + PW'(accept) - PW'(resp);
               if (accept || resp)
                  wdog_nxt = '0;
               else if (wdog != WDOG_MAX)
                  wdog_nxt = wdog + WW'(1);
               if (pend_nxt == '0)
                  state_nxt = IDLE;
               else if (timeout_evt)
                  state_nxt = FLUSH;
            end
            TERM: begin
               // The error for last cycle's accept is due now; further disabled-port requests keep us here.
               m_err = 1'b1;
               if (m_stb && !PORTEN[dport]) begin
                  err_port_nxt = dport;
               end else begin
                  m_stall   = m_stb;
                  state_nxt = IDLE;
               end
            end
            FLUSH: begin
               m_stall  = 1'b1;
               m_err    = 1'b1;
               wdog_nxt = '0;
               pend_nxt = pend - PW'(1);
               if (pend == PW'(1))
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_decode_n.sv
// tb/tb_wb_decode_n.sv - scoreboard bench for wb_decode_n
// Driver pushes expected responses; a negedge monitor pops and compares them.
module tb_wb_decode_n;
   localparam int NP  = 16;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              m_cyc, m_stb, m_we;
   logic [31:0]       m_adr;
   logic [DW/8-1:0]   m_sel;
   logic [DW-1:0]     m_dat_m, m_dat_s;
   logic              m_ack, m_err, m_stall;
   logic [NP-1:0]     s_cyc, s_stb;
   logic              s_we;
   logic [31:0]       s_adr;
   logic [DW/8-1:0]   s_sel;
   logic [DW-1:0]     s_dat_m;
   logic [NP*DW-1:0]  s_dat_s;
   logic [NP-1:0]     s_ack, s_err, s_stall;
   logic              timeout_evt;
   logic [3:0]        err_port;

   wb_decode_n #(.NPORTS(NP), .PSEL_W(4), .PSEL_HI(31), .DWIDTH(DW), .MAXPEND(4),
                 .TIMEOUT(TMO), .PORTEN(16'hFFFD)) dut (
      .clk_i(clk), .rst_i(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
      .m_sel(m_sel), .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_err(m_err),
      .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_sel(s_sel), .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack), .s_err(s_err),
      .s_stall(s_stall), .timeout_evt(timeout_evt), .err_port(err_port));

   typedef struct { logic err; logic [31:0] dat; int at; } exp_t;
   typedef struct { int port; int due; logic [31:0] dat; } sl_t;
   exp_t expq[$];
   sl_t  sq[$];
   exp_t e;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int slave_lat = 0;
   logic [31:0] next_rdata = '0;
   logic [NP-1:0] force_ack = '0;
   logic [NP-1:0] force_err = '0;

   logic [31:0]   b_adr[8];
   logic          b_we[8];
   int            b_kind[8];   // 0 none expected, 1 read data at accept+lat, 2 error at accept+1
   logic [31:0]   b_dat[8];
   int            acc_cyc[8];
   logic [NP-1:0] acc_scyc[8];
   int            burst_start;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Slave model: records accepted strobes at negedge, answers after slave_lat cycles (0 = silent).
   always begin
      @(negedge clk);
      if (!rst && slave_lat > 0)
         for (int p = 0; p < NP; p++)
            if (s_cyc[p] && s_stb[p] && !s_stall[p])
               sq.push_back('{p, cyc + slave_lat, next_rdata});
      @(posedge clk);
      #1;
      s_ack = force_ack;
      s_err = force_err;
      for (int p = 0; p < NP; p++) s_dat_s[p*DW +: DW] = 32'h0BAD_0000 | 32'(p);
      if (sq.size() > 0 && sq[0].due == cyc) begin
         s_ack[sq[0].port] = 1'b1;
         s_dat_s[sq[0].port*DW +: DW] = sq[0].dat;
         void'(sq.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("s_cyc_onehot0", longint'($onehot0(s_cyc)), 1);
         if (m_ack && m_err) check("ack_err_exclusive", 1, 0);
         if (m_ack || m_err) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, nothing owed", m_ack, m_err, cyc);
            end else begin
               e = expq.pop_front();
               if (m_err !== e.err || (!e.err && m_dat_s !== e.dat) || cyc != e.at) begin
                  fails++;
                  $display("FAIL resp: got err=%0b dat=%h cyc=%0d, required err=%0b dat=%h cyc=%0d",
                           m_err, m_dat_s, cyc, e.err, e.dat, e.at);
               end
            end
         end
      end
   end

   task automatic burst(input int n, input int lat);
      int i = 0;
      int guard = 0;
      slave_lat = lat;
      m_cyc = 1'b1;
      while (i < n && guard < 100) begin
         m_stb = 1'b1; m_adr = b_adr[i]; m_we = b_we[i]; next_rdata = b_dat[i];
         @(negedge clk);
         if (guard == 0) burst_start = cyc;
         if (!m_stall) begin
            acc_cyc[i]  = cyc;
            acc_scyc[i] = s_cyc;
            if (b_kind[i] == 1) expq.push_back('{1'b0, b_dat[i], cyc + lat});
            else if (b_kind[i] == 2) expq.push_back('{1'b1, 32'h0, cyc + 1});
            i++;
         end
         @(posedge clk); #1;
         guard++;
      end
      m_stb = 1'b0;
      check("burst_accepts", i, n);
   endtask

   task automatic drain(input string name);
      int g = 0;
      while (expq.size() > 0 && g < 60) begin
         @(posedge clk); #1;
         g++;
      end
      check({"drain_", name}, expq.size(), 0);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_s_cyc"}, s_cyc, 0);
      check({tag, "_s_stb"}, s_stb, 0);
      check({tag, "_m_flags"}, {m_ack, m_err, m_stall, timeout_evt}, 0);
      check({tag, "_err_port"}, err_port, 0);
      check({tag, "_m_dat_s"}, m_dat_s, 0);
   endtask

   task automatic pulse_resp(input int p, input logic err, output int at);
      @(negedge clk);
      force_ack[p] = 1'b1; force_err[p] = err;
      at = cyc + 1;
      @(negedge clk);
      force_ack = '0; force_err = '0;
   endtask

   initial begin
      int t, g, at;
      m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h7000_0000;
      m_sel = 4'hF; m_dat_m = 32'h1234_5678; s_stall = '0;
      repeat (2) @(negedge clk);
      reset_checks("reset");
      @(posedge clk); #1;
      rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
      @(posedge clk); #1;

      // Single read to port 7
      b_adr[0] = 32'h7000_0010; b_we[0] = 0; b_kind[0] = 1; b_dat[0] = 32'hDEAD_BEEF;
      burst(1, 2);
      drain("single");
      check("single_scyc", acc_scyc[0], 16'h0080);
      @(negedge clk);
      check("single_idle_scyc", s_cyc, 0);
      check("single_idle_stall", m_stall, 0);
      @(posedge clk); #1;

      // Six pipelined reads to port 0, MAXPEND caps outstanding at 4
      for (int i = 0; i < 6; i++) begin
         b_adr[i] = 32'h0000_0000 + 32'(4*i); b_we[i] = 0; b_kind[i] = 1;
         b_dat[i] = 32'h1111_0000 + 32'(i);
      end
      burst(6, 5);
      check("pipe_acc3", acc_cyc[3] - acc_cyc[0], 3);
      check("pipe_acc4", acc_cyc[4] - acc_cyc[0], 6);
      check("pipe_acc5", acc_cyc[5] - acc_cyc[0], 7);
      drain("pipe");

      // Port 5 request waits until port 4 drains
      b_adr[0] = 32'h4000_0000; b_kind[0] = 1; b_dat[0] = 32'h4444_4444;
      b_adr[1] = 32'h5000_0000; b_kind[1] = 1; b_dat[1] = 32'h5555_5555;
      burst(2, 3);
      check("switch_gap", acc_cyc[1] - acc_cyc[0], 4);
      drain("switch");

      // Writes to disabled port 1 are terminated internally
      b_adr[0] = 32'h1000_0000; b_we[0] = 1; b_kind[0] = 2;
      b_adr[1] = 32'h1000_0004; b_we[1] = 1; b_kind[1] = 2;
      burst(2, 2);
      check("term_no_stall", acc_cyc[0] - burst_start, 0);
      check("term_pipelined", acc_cyc[1] - acc_cyc[0], 1);
      check("term_scyc", acc_scyc[0] | acc_scyc[1], 0);
      drain("term");
      @(negedge clk);
      check("term_err_port", err_port, 1);
      @(posedge clk); #1;

      // Silent slave on port 3 triggers the watchdog
      b_adr[0] = 32'h3000_0000; b_we[0] = 0; b_kind[0] = 0;
      b_adr[1] = 32'h3000_0004; b_we[1] = 0; b_kind[1] = 0;
      burst(2, 0);
      expq.push_back('{1'b1, 32'h0, acc_cyc[1] + TMO + 2});
      expq.push_back('{1'b1, 32'h0, acc_cyc[1] + TMO + 3});
      t = -1; g = 0;
      while (t < 0 && g < 40) begin
         @(negedge clk);
         if (timeout_evt) t = cyc;
         g++;
      end
      check("tmo_evt_cycle", t, acc_cyc[1] + TMO + 1);
      @(negedge clk);
      check("tmo_evt_pulse", timeout_evt, 0);
      check("tmo_scyc_low", s_cyc, 0);
      check("tmo_err_port", err_port, 3);
      drain("tmo");

      // Simultaneous ack and err on port 6: one error, one decrement
      b_adr[0] = 32'h6000_0000; b_kind[0] = 0;
      burst(1, 0);
      pulse_resp(6, 1'b1, at);
      expq.push_back('{1'b1, 32'h0, at});
      @(posedge clk); #1;
      drain("ackerr");
      b_adr[0] = 32'h2000_0000; b_kind[0] = 1; b_dat[0] = 32'h2222_2222;
      burst(1, 2);
      check("ackerr_released", acc_cyc[0] - burst_start, 0);
      drain("after_ackerr");

      // Master abort with two pending, then a late ack
      b_adr[0] = 32'h3000_0000; b_kind[0] = 0;
      b_adr[1] = 32'h3000_0010; b_kind[1] = 0;
      burst(2, 0);
      m_cyc = 1'b0;
      @(negedge clk);
      check("abort_scyc", s_cyc, 0);
      force_ack[3] = 1'b1;
      @(posedge clk); #1;
      m_cyc = 1'b1;
      @(negedge clk);
      check("abort_late_ack", {m_ack, m_err}, 0);
      force_ack = '0;
      @(posedge clk); #1;
      b_adr[0] = 32'h0000_0020; b_kind[0] = 1; b_dat[0] = 32'h0C0C_0C0C;
      burst(1, 2);
      check("abort_pend_zero", acc_cyc[0] - burst_start, 0);
      drain("abort");

      // Reset pulse mid-transfer
      b_adr[0] = 32'h0000_0040; b_kind[0] = 0;
      burst(1, 0);
      rst = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_0000;
      @(negedge clk);
      reset_checks("midrst");
      @(posedge clk); #1;
      rst = 1'b0; m_stb = 1'b0;
      @(negedge clk);
      force_ack[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_late_ack", {m_ack, m_err}, 0);
      force_ack = '0;
      @(posedge clk); #1;
      m_cyc = 1'b0;
      repeat (2) @(posedge clk);
      check("final_expq_empty", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete, required completion");
      $fatal(1, "global timeout");
   end
endmodule
